// File: rtl/sha1_sched_pkg.sv
// Shared widths, SHA-1 initial chaining value and state helpers for the SHA-1 issue scheduler.
package sha1_sched_pkg;

  localparam int unsigned SHA1_MSG_W   = 512;
  localparam int unsigned SHA1_STATE_W = 160;

  localparam logic [31:0] SHA1_IV_A = 32'h67452301;
  localparam logic [31:0] SHA1_IV_B = 32'hefcdab89;
  localparam logic [31:0] SHA1_IV_C = 32'h98badcfe;
  localparam logic [31:0] SHA1_IV_D = 32'h10325476;
  localparam logic [31:0] SHA1_IV_E = 32'hc3d2e1f0;
  localparam logic [SHA1_STATE_W-1:0] SHA1_IV =
    {SHA1_IV_A, SHA1_IV_B, SHA1_IV_C, SHA1_IV_D, SHA1_IV_E};

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] d;
    logic [31:0] e;
  } sha1_state_t;

  function automatic sha1_state_t sha1_unpack(input logic [SHA1_STATE_W-1:0] v);
    return sha1_state_t'(v);
  endfunction

  function automatic logic [SHA1_STATE_W-1:0] sha1_pack(input sha1_state_t s);
    return SHA1_STATE_W'(s);
  endfunction

  // Word-wise modulo 2^32 add; carries never cross a word boundary.
  function automatic logic [SHA1_STATE_W-1:0] sha1_add(input logic [SHA1_STATE_W-1:0] x,
                                                       input logic [SHA1_STATE_W-1:0] y);
    sha1_state_t sx, sy, sr;
    sx   = sha1_unpack(x);
    sy   = sha1_unpack(y);
    sr.a = sx.a + sy.a;
    sr.b = sx.b + sy.b;
    sr.c = sx.c + sy.c;
    sr.d = sx.d + sy.d;
    sr.e = sx.e + sy.e;
    return sha1_pack(sr);
  endfunction

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sha1_rr_arbiter.sv
// Round-robin arbiter: one-hot grant and encoded winner, search starts at the owned pointer.
module sha1_rr_arbiter
  import sha1_sched_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        eligible,
  output logic [NREQ-1:0]        grant,
  output logic                   grant_valid,
  output logic [clog2(NREQ)-1:0] grant_idx
);

  localparam int unsigned IDW = clog2(NREQ);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = wrap_idx(ptr, k);
      if (!grant_valid && eligible[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_valid) begin
      ptr <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sha1_issue_sched.sv
// Round-robin issue scheduler sharing one LATENCY-deep SHA-1 pipeline between NREQ requesters.
// Define SHA1_SCHED_FEEDFWD_EN to add each requester's captured chaining IV to its result.
module sha1_issue_sched
  import sha1_sched_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 80
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*SHA1_MSG_W-1:0]   req_msg,
  input  logic [NREQ*SHA1_STATE_W-1:0] req_iv,
  output logic [NREQ-1:0]              req_ready,
  output logic [SHA1_MSG_W-1:0]        pipe_msg,
  output logic [SHA1_STATE_W-1:0]      pipe_state_in,
  input  logic [SHA1_STATE_W-1:0]      pipe_state_out,
  output logic                         rsp_valid,
  output logic [clog2(NREQ)-1:0]       rsp_id,
  output logic [SHA1_STATE_W-1:0]      rsp_hash,
  output logic [NREQ-1:0]              busy
);

  localparam int unsigned IDW = clog2(NREQ);

  logic [NREQ-1:0]         eligible;
  logic                    grant_valid;
  logic [IDW-1:0]          grant_idx;
  logic [LATENCY-1:0]      dl_valid;
  logic [IDW-1:0]          dl_id [LATENCY];
  logic                    tail_valid;
  logic [IDW-1:0]          tail_id;
  logic [SHA1_STATE_W-1:0] result;

  assign eligible = req_valid & ~busy;

  sha1_rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .eligible    (eligible),
    .grant       (req_ready),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    pipe_msg      = '0;
    pipe_state_in = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        pipe_msg      = req_msg[i*SHA1_MSG_W +: SHA1_MSG_W];
        pipe_state_in = req_iv[i*SHA1_STATE_W +: SHA1_STATE_W];
      end
    end
  end

  // Tag delay line tracks the pipeline; only the valids need reset to drop in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_valid <= '0;
    end else begin
      dl_valid[0] <= grant_valid;
      for (int unsigned s = 1; s < LATENCY; s++) dl_valid[s] <= dl_valid[s-1];
    end
  end

  always_ff @(posedge clk) begin
    dl_id[0] <= grant_idx;
    for (int unsigned s = 1; s < LATENCY; s++) dl_id[s] <= dl_id[s-1];
  end

  assign tail_valid = dl_valid[LATENCY-1];
  assign tail_id    = dl_id[LATENCY-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (tail_valid && tail_id == IDW'(i)) busy[i] <= 1'b0;
        if (req_ready[i]) busy[i] <= 1'b1;
      end
    end
  end

`ifdef SHA1_SCHED_FEEDFWD_EN
  logic [SHA1_STATE_W-1:0] iv_q [NREQ];

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_ready[i]) iv_q[i] <= req_iv[i*SHA1_STATE_W +: SHA1_STATE_W];
    end
  end

  assign result = sha1_add(pipe_state_out, iv_q[tail_id]);
`else
  assign result = pipe_state_out;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_hash  <= '0;
    end else begin
      rsp_valid <= tail_valid;
      if (tail_valid) begin
        rsp_id   <= tail_id;
        rsp_hash <= result;
      end
    end
  end

endmodule

// File: tb/tb_sha1_issue_sched.sv
// Self-checking bench for sha1_issue_sched with a behavioural SHA-1 pipeline and a response scoreboard.
module tb_sha1_issue_sched;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 80;

  localparam logic [159:0] IV_STD = {32'h67452301, 32'hefcdab89, 32'h98badcfe,
                                     32'h10325476, 32'hc3d2e1f0};
  localparam logic [511:0] MSG_HELLO = {32'h00000058, 384'h0, 32'h726c6480,
                                        32'h6f20776f, 32'h68656c6c};
  localparam logic [511:0] MSG_HELLL = {32'h00000058, 384'h0, 32'h726c6480,
                                        32'h6c20776f, 32'h68656c6c};
`ifdef SHA1_SCHED_FEEDFWD_EN
  localparam logic [31:0] A_HELLO = 32'h2aae6c35;
`else
  localparam logic [31:0] A_HELLO = 32'hc3694934;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*512-1:0] req_msg = '0;
  logic [NREQ*160-1:0] req_iv = '0;
  logic [NREQ-1:0]     req_ready;
  logic [511:0]        pipe_msg;
  logic [159:0]        pipe_state_in;
  logic [159:0]        pipe_state_out;
  logic                rsp_valid;
  logic [1:0]          rsp_id;
  logic [159:0]        rsp_hash;
  logic [NREQ-1:0]     busy;

  always #5 clk = ~clk;

  sha1_issue_sched #(
    .NREQ    (NREQ),
    .LATENCY (LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_msg        (req_msg),
    .req_iv         (req_iv),
    .req_ready      (req_ready),
    .pipe_msg       (pipe_msg),
    .pipe_state_in  (pipe_state_in),
    .pipe_state_out (pipe_state_out),
    .rsp_valid      (rsp_valid),
    .rsp_id         (rsp_id),
    .rsp_hash       (rsp_hash),
    .busy           (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [159:0] sha1_raw(input logic [511:0] m, input logic [159:0] s);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
    for (int i = 16; i < 80; i++) begin
      t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    {a, b, c, d, e} = s;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
      else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {a, b, c, d, e};
  endfunction

  function automatic logic [159:0] exp_hash(input int unsigned i);
    logic [159:0] v, r;
    v = req_iv[160*i +: 160];
    r = sha1_raw(req_msg[512*i +: 512], v);
`ifdef SHA1_SCHED_FEEDFWD_EN
    for (int wd = 0; wd < 5; wd++) r[32*wd +: 32] = r[32*wd +: 32] + v[32*wd +: 32];
`endif
    return r;
  endfunction

  // Behavioural stand-in for the shared pipeline: LAT register stages, no reset.
  logic [159:0] pipe_q [LAT];
  always @(posedge clk) begin
    pipe_q[0] <= sha1_raw(pipe_msg, pipe_state_in);
    for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
  end
  assign pipe_state_out = pipe_q[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned  id;
    logic [159:0] hash;
    int unsigned  due;
  } sb_t;
  sb_t sb [$];

  int unsigned     m_ptr = 0;
  logic [NREQ-1:0] m_infl = '0;
  int unsigned     m_done [NREQ];

  always @(negedge clk) begin
    logic [NREQ-1:0] mb, er;
    int unsigned     idx;
    sb_t             ent;
    if (rst) begin
      sb.delete();
      m_ptr  = 0;
      m_infl = '0;
    end else begin
      for (int i = 0; i < NREQ; i++) mb[i] = m_infl[i] && (cyc < m_done[i]);
      check("busy", busy, mb);
      er = '0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (er == '0 && req_valid[idx] && !mb[idx]) er[idx] = 1'b1;
      end
      check("req_ready", req_ready, er);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", rsp_valid, 1'b0);
        end else begin
          ent = sb.pop_front();
          check("rsp_id", rsp_id, ent.id);
          check("rsp_hash", rsp_hash, ent.hash);
          check("rsp_cycle", cyc, ent.due);
        end
      end
      if (er == '0) begin
        check("pipe_msg_idle", pipe_msg, '0);
        check("pipe_iv_idle", pipe_state_in, '0);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (er[i]) begin
          check("pipe_msg", pipe_msg, req_msg[512*i +: 512]);
          check("pipe_iv", pipe_state_in, req_iv[160*i +: 160]);
          ent.id   = i;
          ent.hash = exp_hash(i);
          ent.due  = cyc + LAT + 1;
          sb.push_back(ent);
          m_infl[i] = 1'b1;
          m_done[i] = cyc + LAT + 1;
          m_ptr     = (i + 1) % NREQ;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 3 * LAT && sb.size() != 0; k++) tick();
    check("drain", sb.size(), 0);
  endtask

  task automatic rand_req(input int unsigned i);
    for (int w = 0; w < 16; w++) req_msg[512*i + 32*w +: 32] = $urandom();
    for (int w = 0; w < 5; w++) req_iv[160*i + 32*w +: 32] = $urandom();
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < LAT + 10; k++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
  endtask

  initial begin
    int unsigned errs, cnt;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, '0);
    check("rst_rsp_hash", rsp_hash, '0);
    check("rst_busy", busy, '0);
    check("rst_ready", req_ready, '0);
    check("rst_pipe_msg", pipe_msg, '0);
    rst = 1'b0;

    // Single issue of "hello world" from requester 0
    tick();
    req_msg[0 +: 512] = MSG_HELLO;
    req_iv[0 +: 160]  = IV_STD;
    req_valid         = 4'b0001;
    @(negedge clk);
    check("t1_grant", req_ready, 4'b0001);
    tick();
    req_valid        = '0;
    req_iv[0 +: 160] = {5{32'hdeadbeef}};
    wait_rsp();
    check("t1_rsp_valid", rsp_valid, 1'b1);
    check("t1_rsp_id", rsp_id, 2'd0);
    check("t1_a_word", rsp_hash[159:128], A_HELLO);
    drain();

    // Two requesters in the same cycle
    do_reset();
    req_msg[0 +: 512]   = MSG_HELLO;
    req_msg[512 +: 512] = MSG_HELLL;
    req_iv[0 +: 160]    = IV_STD;
    req_iv[160 +: 160]  = IV_STD;
    req_valid           = 4'b0011;
    @(negedge clk);
    check("t2_grant0", req_ready, 4'b0001);
    tick();
    @(negedge clk);
    check("t2_grant1", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_rsp();
    check("t2_rsp0_valid", rsp_valid, 1'b1);
    check("t2_rsp0_id", rsp_id, 2'd0);
    check("t2_rsp0_a", rsp_hash[159:128], A_HELLO);
    @(negedge clk);
    check("t2_rsp1_valid", rsp_valid, 1'b1);
    check("t2_rsp1_id", rsp_id, 2'd1);
`ifdef SHA1_SCHED_FEEDFWD_EN
    check("t2_rsp1_a", rsp_hash[159:128], 32'hc7fa8d5b);
`endif
    drain();

    // All four requesters continuously valid
    do_reset();
    for (int i = 0; i < NREQ; i++) rand_req(i);
    req_valid = '1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rot_grant", req_ready, 4'b0001 << k);
      tick();
    end
    errs = 0;
    for (int k = 4; k <= LAT; k++) begin
      @(negedge clk);
      if (req_ready != '0) errs++;
      tick();
    end
    check("rot_idle_grants", errs, 0);
    @(negedge clk);
    check("rot_regrant0", req_ready, 4'b0001);
    check("rot_rsp0_valid", rsp_valid, 1'b1);
    check("rot_rsp0_id", rsp_id, 2'd0);
    tick();
    req_valid = '0;
    drain();

    // Only requester 2, back-to-back issues
    do_reset();
    rand_req(2);
    req_valid = 4'b0100;
    errs      = 0;
    for (int k = 0; k < 3 * (LAT + 1); k++) begin
      @(negedge clk);
      if (req_ready != (((k % (LAT + 1)) == 0) ? 4'b0100 : 4'b0000)) errs++;
      if (busy[2] != ((k % (LAT + 1)) != 0)) errs++;
      tick();
    end
    req_valid = '0;
    check("r2_pattern_errs", errs, 0);
    drain();

    // Reset while work is in flight
    do_reset();
    for (int i = 0; i < NREQ; i++) rand_req(i);
    req_valid = 4'b1001;
    @(negedge clk);
    check("rr_grant0", req_ready, 4'b0001);
    tick();
    @(negedge clk);
    check("rr_grant3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0010;
    @(negedge clk);
    check("rr_grant1", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    cnt  = 0;
    errs = 0;
    for (int k = 0; k < LAT + 5; k++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
      if (busy != '0) errs++;
      tick();
    end
    check("rr_no_rsp", cnt, 0);
    check("rr_busy_clear", errs, 0);
    req_valid = '1;
    @(negedge clk);
    check("rr_ptr_restart", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sha1_issue_sched.md
# sha1_issue_sched

Round-robin issue scheduler sharing one fully unrolled, one-message-per-cycle `sha1_pipeline` between `NREQ` requesters. Each requester has at most one block in flight. The scheduler tags every issue, tracks the tag through a delay line matched to the pipeline depth, and returns the result to its owner. Compiled with the feedforward option, it also adds the chaining IV, so each result is a finished compression. It sits between the PBKDF2/HMAC iteration engines and the shared SHA-1 core.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (≥2).
- `LATENCY`, 80, cycles from `pipe_msg`/`pipe_state_in` to matching `pipe_state_out`. Must equal the instantiated pipeline depth.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  requester i has a block to issue.
- `req_msg`  in  NREQ*512  message block; slice i is `[512*i +: 512]`, word 0 in bits [31:0].
- `req_iv`  in  NREQ*160  chaining state {a,b,c,d,e}, a in [159:128].
- `req_ready`  out  NREQ  one-hot; request i is accepted this cycle.
- `pipe_msg`  out  512  to pipeline `msg_in`.
- `pipe_state_in`  out  160  to pipeline a..e inputs.
- `pipe_state_out`  in  160  from pipeline a..e outputs.
- `rsp_valid`  out  1  result valid.
- `rsp_id`  out  clog2(NREQ)  owner of result.
- `rsp_hash`  out  160  result {a,b,c,d,e}.
- `busy`  out  NREQ  requester i has a block in flight.

## Operation
- Eligible(i) = `req_valid[i] && !busy[i]`.
- Arbitration:
  - Round-robin starting at pointer `ptr`; the first eligible index at or after `ptr` (mod NREQ) wins.
  - `req_ready` is combinational and one-hot; it is all-zero when nothing is eligible.
  - On a grant, `ptr` ← winner+1 mod NREQ. With no grant, `ptr` is held.
- Issue:
  - On a grant, `pipe_msg`/`pipe_state_in` carry the winner's slices combinationally.
  - With no grant, both are driven to zero.
  - The pipeline never stalls; an issue slot is used or wasted every cycle.
- Tracking:
  - A delay line of depth `LATENCY` carries {valid, id}.
  - Its head is loaded with {grant, winner}.
  - On grant, `busy[winner]` is set at the clock edge.
- Return:
  - When the tail is valid, `rsp_valid`, `rsp_id` and `rsp_hash` are registered next cycle.
  - `busy[id]` clears on that same edge.
  - No backpressure. Requesters must capture the result in the `rsp_valid` cycle.
- Arithmetic: feedforward add is per 32-bit word, modulo 2^32. Carries do not cross words.
- Simultaneous events:
  - A requester whose result is registered at edge t is eligible in cycle t and may be re-granted immediately.
  - One issue and one return per cycle is normal steady state.
- Reset:
  - `rst` clears `busy`, all delay-line valids, `ptr`=0, `rsp_valid`=0, `rsp_id`=0 and `rsp_hash`=0.
  - In-flight results are discarded; their pipeline outputs are ignored because their tags are invalid.

## Timing
- Grant and drive to the pipeline: same cycle (combinational from `req_valid` and `busy`).
- Issue at edge t0 → `rsp_valid` high for exactly one cycle after edge t0+LATENCY+1.
- Throughput: 1 block/cycle aggregate; per requester, 1 block per LATENCY+1 cycles.
- All outputs except `req_ready`, `pipe_msg` and `pipe_state_in` are registered.

## Configuration
- `SHA1_SCHED_FEEDFWD_EN` defined:
  - `req_iv[i]` is captured into a per-requester IV register on grant.
  - `rsp_hash` = `pipe_state_out` + IV register[id], per word.
- Undefined:
  - IV registers are removed.
  - `rsp_hash` = raw `pipe_state_out`, for benches that compare pre-add state.
  - `req_iv` still drives `pipe_state_in`.

## Structure
- Shared package `sha1_sched_pkg`:
  - `SHA1_MSG_W`=512, `SHA1_STATE_W`=160.
  - Standard IV constants 67452301, efcdab89, 98badcfe, 10325476, c3d2e1f0.
  - State pack/unpack functions and `clog2`.
- Sub-module `sha1_rr_arbiter` (parameter `NREQ`): eligible vector in, one-hot grant plus encoded index out, owns `ptr`.
- Delay line, busy bits and IV registers live in the top.

## Test plan
- Single issue: requester 0 issues padded "hello world" (length 0x58) with standard IV, feedforward on → after LATENCY+1 cycles, `rsp_valid`=1, `rsp_id`=0, `rsp_hash[159:128]`=2aae6c35.
- Same message, macro off → `rsp_hash[159:128]`=c3694934.
- All four requesters valid continuously:
  - Grants rotate 0,1,2,3 in consecutive cycles, then no grants until returns.
  - Re-issue of 0 happens in the cycle its response is registered.
- Requester 1 issues "helll world" while 0 issues "hello world" → two responses one cycle apart, ids 0 then 1, a-words 2aae6c35 and c7fa8d5b.
- Only requester 2 valid for 3×(LATENCY+1) cycles → three responses, each LATENCY+1 apart, `busy[2]` high between them.
- `rst` asserted 10 cycles after issuing to 0 and 3 → no `rsp_valid` for the next LATENCY+5 cycles, `busy`=0, `ptr` restarts at 0.
